// File: rtl/rv16_alu_pkg.sv
// Shared definitions for the rv16 ALU and its request arbiter:
// op encodings, arbiter FSM states and flag bit positions.
package rv16_alu_pkg;

   localparam int unsigned OP_W       = 4;
   localparam int unsigned FLAG_W     = 3;
   localparam int unsigned FLAG_ZERO  = 0;
   localparam int unsigned FLAG_OVF   = 1;
   localparam int unsigned FLAG_CARRY = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_SLL  = 4'h5,
      OP_SRL  = 4'h6,
      OP_SRA  = 4'h7,
      OP_MUL  = 4'h8,
      OP_SLT  = 4'h9,
      OP_SLTU = 4'hA
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   // Encodings above OP_SLTU are reserved and produce a zero result with no flags.
   function automatic logic is_supported(input logic [OP_W-1:0] op);
      return (op <= OP_SLTU);
   endfunction

endpackage

// File: rtl/rv16_alu.sv
// Combinational ALU datapath: arithmetic, logic, shifts, low-half multiply
// and set-less-than, with zero/overflow/carry flags.
module rv16_alu
   import rv16_alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
)
(
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result_c,
   output logic [FLAG_W-1:0] flags_c
);

   localparam int unsigned SH_W = $clog2(DATA_W);

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] prod;
   logic [SH_W-1:0]   shamt;
   logic              ovf_add;
   logic              ovf_sub;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign diff  = {1'b0, a} - {1'b0, b};
   assign prod  = a * b;
   assign shamt = b[SH_W-1:0];

   // Signed overflow: operand signs allow it and the result sign disagrees with a.
   assign ovf_add = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
   assign ovf_sub = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

   always_comb begin
      result_c = '0;
      flags_c  = '0;
      case (alu_op_e'(op))
         OP_ADD: begin
            result_c              = sum[DATA_W-1:0];
            flags_c[FLAG_CARRY]   = sum[DATA_W];
            flags_c[FLAG_OVF]     = ovf_add;
         end
         OP_SUB: begin
            result_c              = diff[DATA_W-1:0];
            flags_c[FLAG_CARRY]   = diff[DATA_W];
            flags_c[FLAG_OVF]     = ovf_sub;
         end
         OP_AND:  result_c = a & b;
         OP_OR:   result_c = a | b;
         OP_XOR:  result_c = a ^ b;
         OP_SLL:  result_c = a << shamt;
         OP_SRL:  result_c = a >> shamt;
         OP_SRA:  result_c = $unsigned($signed(a) >>> shamt);
         OP_MUL:  result_c = prod;
         OP_SLT:  result_c = DATA_W'($signed(a) < $signed(b));
         OP_SLTU: result_c = DATA_W'(a < b);
         default: result_c = '0;
      endcase
      flags_c[FLAG_ZERO] = is_supported(op) && (result_c == '0);
   end

endmodule

// File: rtl/rv16_alu_arbiter.sv
// Round-robin arbiter sharing one rv16_alu between N_REQ requesters, with
// registered issue operands and a registered, back-pressured response channel.
module rv16_alu_arbiter
   import rv16_alu_pkg::*;
#(
   parameter int unsigned N_REQ  = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned ID_W   = 2
)
(
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ-1:0]          i_req_valid,
   output logic [N_REQ-1:0]          o_req_ready,
   input  logic [N_REQ*OP_W-1:0]     i_req_op,
   input  logic [N_REQ*DATA_W-1:0]   i_req_a,
   input  logic [N_REQ*DATA_W-1:0]   i_req_b,
   input  logic [N_REQ*TAG_W-1:0]    i_req_tag,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [ID_W-1:0]           o_rsp_id,
   output logic [TAG_W-1:0]          o_rsp_tag,
   output logic [DATA_W-1:0]         o_rsp_result,
   output logic                      o_rsp_zero,
   output logic                      o_rsp_overflow,
   output logic                      o_rsp_carry,
   output logic                      o_busy
);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [ID_W-1:0]   rr_q;
   logic [ID_W-1:0]   rr_d;

   logic [N_REQ-1:0]  valid_rot;
   logic [N_REQ-1:0]  pick_rot;
   logic [N_REQ-1:0]  grant;
   logic              grant_any;
   logic [ID_W-1:0]   grant_idx;
   logic              accept_ok;
   logic              take;

   logic [OP_W-1:0]   sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [TAG_W-1:0]  sel_tag;

   logic [OP_W-1:0]   iss_op_q;
   logic [DATA_W-1:0] iss_a_q;
   logic [DATA_W-1:0] iss_b_q;
   logic [TAG_W-1:0]  iss_tag_q;
   logic [ID_W-1:0]   iss_id_q;

   logic [DATA_W-1:0] rsp_result_q;
   logic [FLAG_W-1:0] rsp_flags_q;
   logic [TAG_W-1:0]  rsp_tag_q;
   logic [ID_W-1:0]   rsp_id_q;

   logic [DATA_W-1:0] alu_result_c;
   logic [FLAG_W-1:0] alu_flags_c;

   // Rotate valids so the search start sits at bit 0, pick lowest, rotate back.
   always_comb begin
      valid_rot = N_REQ'({i_req_valid, i_req_valid} >> rr_q);
      pick_rot  = '0;
      grant_any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (valid_rot[k] && !grant_any) begin
            pick_rot[k] = 1'b1;
            grant_any   = 1'b1;
         end
      end
      grant = N_REQ'(({pick_rot, pick_rot} << rr_q) >> N_REQ);

      grant_idx = '0;
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_tag   = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (grant[j]) begin
            grant_idx = ID_W'(j);
            sel_op    = i_req_op[j*OP_W +: OP_W];
            sel_a     = i_req_a[j*DATA_W +: DATA_W];
            sel_b     = i_req_b[j*DATA_W +: DATA_W];
            sel_tag   = i_req_tag[j*TAG_W +: TAG_W];
         end
      end
      rr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   // A grant is only offered when the issue slot is free or being freed this cycle.
   assign accept_ok   = (state_q == ST_IDLE) || ((state_q == ST_RESP) && i_rsp_ready);
   assign take        = grant_any && accept_ok;
   assign o_req_ready = grant & {N_REQ{accept_ok}};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (take) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            if (i_rsp_ready) state_d = take ? ST_EXEC : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Issue registers and rr pointer load on a grant; response registers load in EXEC.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rr_q         <= '0;
         iss_op_q     <= '0;
         iss_a_q      <= '0;
         iss_b_q      <= '0;
         iss_tag_q    <= '0;
         iss_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_tag_q    <= '0;
         rsp_id_q     <= '0;
      end else begin
         if (take) begin
            rr_q      <= rr_d;
            iss_op_q  <= sel_op;
            iss_a_q   <= sel_a;
            iss_b_q   <= sel_b;
            iss_tag_q <= sel_tag;
            iss_id_q  <= grant_idx;
         end
         if (state_q == ST_EXEC) begin
            rsp_result_q <= alu_result_c;
            rsp_flags_q  <= alu_flags_c;
            rsp_tag_q    <= iss_tag_q;
            rsp_id_q     <= iss_id_q;
         end
      end
   end

   rv16_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op       (iss_op_q),
      .a        (iss_a_q),
      .b        (iss_b_q),
      .result_c (alu_result_c),
      .flags_c  (alu_flags_c)
   );

   assign o_rsp_valid    = (state_q == ST_RESP);
   assign o_busy         = (state_q != ST_IDLE);
   assign o_rsp_id       = rsp_id_q;
   assign o_rsp_tag      = rsp_tag_q;
   assign o_rsp_result   = rsp_result_q;
   assign o_rsp_zero     = rsp_flags_q[FLAG_ZERO];
   assign o_rsp_overflow = rsp_flags_q[FLAG_OVF];
   assign o_rsp_carry    = rsp_flags_q[FLAG_CARRY];

endmodule

// File: tb/tb_rv16_alu_arbiter.sv
// Directed bench for rv16_alu_arbiter: arithmetic flags, round-robin order,
// backpressure, async reset and unsupported-op handling.
module tb_rv16_alu_arbiter;
   import rv16_alu_pkg::*;

   localparam int unsigned N_REQ  = 2;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned ID_W   = 2;

   logic                    i_clk;
   logic                    i_rst;
   logic [N_REQ-1:0]        i_req_valid;
   logic [N_REQ-1:0]        o_req_ready;
   logic [N_REQ*OP_W-1:0]   i_req_op;
   logic [N_REQ*DATA_W-1:0] i_req_a;
   logic [N_REQ*DATA_W-1:0] i_req_b;
   logic [N_REQ*TAG_W-1:0]  i_req_tag;
   logic                    o_rsp_valid;
   logic                    i_rsp_ready;
   logic [ID_W-1:0]         o_rsp_id;
   logic [TAG_W-1:0]        o_rsp_tag;
   logic [DATA_W-1:0]       o_rsp_result;
   logic                    o_rsp_zero;
   logic                    o_rsp_overflow;
   logic                    o_rsp_carry;
   logic                    o_busy;

   int errors = 0;
   int checks = 0;

   rv16_alu_arbiter #(
      .N_REQ  (N_REQ),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .ID_W   (ID_W)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_op       (i_req_op),
      .i_req_a        (i_req_a),
      .i_req_b        (i_req_b),
      .i_req_tag      (i_req_tag),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_id       (o_rsp_id),
      .o_rsp_tag      (o_rsp_tag),
      .o_rsp_result   (o_rsp_result),
      .o_rsp_zero     (o_rsp_zero),
      .o_rsp_overflow (o_rsp_overflow),
      .o_rsp_carry    (o_rsp_carry),
      .o_busy         (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
      i_req_op[idx*4 +: 4]   = op;
      i_req_a[idx*32 +: 32]  = a;
      i_req_b[idx*32 +: 32]  = b;
      i_req_tag[idx*4 +: 4]  = tag;
   endtask

   task automatic check_rsp(input string name, input logic [1:0] id, input logic [3:0] tag,
                            input logic [31:0] res, input logic z, input logic o, input logic c);
      check({name, ".valid"}, 64'(o_rsp_valid), 64'(1'b1));
      check({name, ".id"},    64'(o_rsp_id), 64'(id));
      check({name, ".tag"},   64'(o_rsp_tag), 64'(tag));
      check({name, ".res"},   64'(o_rsp_result), 64'(res));
      check({name, ".zero"},  64'(o_rsp_zero), 64'(z));
      check({name, ".ovf"},   64'(o_rsp_overflow), 64'(o));
      check({name, ".carry"}, 64'(o_rsp_carry), 64'(c));
   endtask

   initial begin
      i_rst       = 1'b1;
      i_req_valid = '0;
      i_req_op    = '0;
      i_req_a     = '0;
      i_req_b     = '0;
      i_req_tag   = '0;
      i_rsp_ready = 1'b1;
      step();
      step();
      check("rst.valid", 64'(o_rsp_valid), 64'(0));
      check("rst.busy",  64'(o_busy), 64'(0));
      check("rst.ready", 64'(o_req_ready), 64'(0));
      check("rst.res",   64'(o_rsp_result), 64'(0));
      check("rst.tag",   64'(o_rsp_tag), 64'(0));
      i_rst = 1'b0;

      // Signed overflow on ADD, response two edges after accept
      set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'h1, 4'h3);
      i_req_valid = 2'b01;
      #1 check("add.ready", 64'(o_req_ready), 64'(2'b01));
      step();
      check("add.exec_busy",  64'(o_busy), 64'(1));
      check("add.exec_valid", 64'(o_rsp_valid), 64'(0));
      check("add.exec_ready", 64'(o_req_ready), 64'(0));
      i_req_valid = 2'b00;
      step();
      check_rsp("add_ovf", 2'd0, 4'h3, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      step();
      check("add.idle_busy", 64'(o_busy), 64'(0));

      // SUB zero, then SUB with borrow granted in the same cycle as the handshake
      set_req(1, OP_SUB, 32'd5, 32'd5, 4'h5);
      i_req_valid = 2'b10;
      #1 check("sub0.ready", 64'(o_req_ready), 64'(2'b10));
      step();
      i_req_valid = 2'b00;
      step();
      check_rsp("sub_zero", 2'd1, 4'h5, 32'h0, 1'b1, 1'b0, 1'b0);
      set_req(1, OP_SUB, 32'd3, 32'd5, 4'h6);
      i_req_valid = 2'b10;
      #1 check("sub1.ready_in_resp", 64'(o_req_ready), 64'(2'b10));
      step();
      check("sub1.valid_drop", 64'(o_rsp_valid), 64'(0));
      check("sub1.busy",       64'(o_busy), 64'(1));
      i_req_valid = 2'b00;
      step();
      check_rsp("sub_borrow", 2'd1, 4'h6, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      step();

      // Both requesters continuously valid: strict 0,1,0,1 rotation
      set_req(0, OP_ADD, 32'd1, 32'd1, 4'h1);
      set_req(1, OP_ADD, 32'd2, 32'd2, 4'h2);
      i_req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1 check("rr.ready", 64'(o_req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
         step();
         check("rr.exec_valid", 64'(o_rsp_valid), 64'(0));
         step();
         if (i % 2 == 0) check_rsp("rr0", 2'd0, 4'h1, 32'd2, 1'b0, 1'b0, 1'b0);
         else            check_rsp("rr1", 2'd1, 4'h2, 32'd4, 1'b0, 1'b0, 1'b0);
      end

      // Backpressure: response held, no grant offered while stalled
      i_rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp.valid", 64'(o_rsp_valid), 64'(1));
         check("bp.res",   64'(o_rsp_result), 64'(4));
         check("bp.id",    64'(o_rsp_id), 64'(1));
         check("bp.tag",   64'(o_rsp_tag), 64'(2));
         check("bp.ready", 64'(o_req_ready), 64'(0));
         check("bp.busy",  64'(o_busy), 64'(1));
      end
      i_rsp_ready = 1'b1;
      #1 check("bp.release_ready", 64'(o_req_ready), 64'(2'b01));
      step();
      i_req_valid = 2'b10;
      step();
      check_rsp("bp_req0", 2'd0, 4'h1, 32'd2, 1'b0, 1'b0, 1'b0);
      check("bp.ready1", 64'(o_req_ready), 64'(2'b10));
      step();
      i_req_valid = 2'b00;
      step();
      check_rsp("bp_req1", 2'd1, 4'h2, 32'd4, 1'b0, 1'b0, 1'b0);
      step();

      // Async reset in EXEC drops the op and restores requester-0 priority
      set_req(0, OP_ADD, 32'd10, 32'd20, 4'hA);
      i_req_valid = 2'b01;
      step();
      i_req_valid = 2'b00;
      check("rstx.busy_pre", 64'(o_busy), 64'(1));
      i_rst = 1'b1;
      #1;
      check("rstx.busy",  64'(o_busy), 64'(0));
      check("rstx.valid", 64'(o_rsp_valid), 64'(0));
      step();
      check("rstx.still_idle", 64'(o_rsp_valid), 64'(0));
      i_rst = 1'b0;
      set_req(0, OP_ADD, 32'd7, 32'd8, 4'hB);
      set_req(1, OP_SUB, 32'd9, 32'd4, 4'hC);
      i_req_valid = 2'b11;
      #1 check("rstx.tie_ready", 64'(o_req_ready), 64'(2'b01));
      step();
      i_req_valid = 2'b10;
      step();
      check_rsp("rstx_req0", 2'd0, 4'hB, 32'd15, 1'b0, 1'b0, 1'b0);
      check("rstx.ready1", 64'(o_req_ready), 64'(2'b10));
      step();
      i_req_valid = 2'b00;
      step();
      check_rsp("rstx_req1", 2'd1, 4'hC, 32'd5, 1'b0, 1'b0, 1'b0);
      step();

      // MUL keeps the low half only; reserved op still gets a response
      set_req(0, OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'h4);
      i_req_valid = 2'b01;
      step();
      i_req_valid = 2'b00;
      step();
      check_rsp("mul", 2'd0, 4'h4, 32'h0, 1'b1, 1'b0, 1'b0);
      step();
      set_req(1, 4'hF, 32'd5, 32'd7, 4'h9);
      i_req_valid = 2'b10;
      #1 check("unsup.ready", 64'(o_req_ready), 64'(2'b10));
      step();
      i_req_valid = 2'b00;
      step();
      check_rsp("unsup", 2'd1, 4'h9, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("end.busy", 64'(o_busy), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
